// File: rtl/poly_osc_pkg.sv
// poly_osc_pkg: shared constants and helpers for the poly_osc oscillator bank.
//   NOTE_MAX   - highest valid MIDI note
//   H_MUTE     - half-period encoding for a silent voice
//   mix_w()    - width of the voice-count mix output
//   note_half()- elaboration-time half-period for one note, saturated to mute
package poly_osc_pkg;

    localparam int     NOTE_MAX = 127;
    localparam longint H_MUTE   = 0;

    function automatic int mix_w(input int voices);
        return $clog2(voices + 1);
    endfunction

    // Evaluated only as a constant function while building the note table.
    function automatic longint note_half(input int n, input int clk_hz, input int cnt_bw);
        real    f;
        real    h;
        longint hi;
        if (n > NOTE_MAX) return H_MUTE;
        f  = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
        h  = real'(clk_hz) / (2.0 * f);
        hi = longint'($rtoi(h + 0.5));
        // A half-period that does not fit the counter is treated as mute.
        if (hi > ((longint'(1) << cnt_bw) - 1)) return H_MUTE;
        return hi;
    endfunction

endpackage

// File: rtl/poly_note_lut.sv
// poly_note_lut: combinational MIDI note -> half-period lookup.
//   note_i [7:0]        MIDI note; values above NOTE_MAX map to mute
//   h_o    [CNT_BW-1:0] half-period in clock cycles, 0 = mute
module poly_note_lut
    import poly_osc_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_BW = 22
) (
    input  logic [7:0]        note_i,
    output logic [CNT_BW-1:0] h_o
);

    logic [CNT_BW-1:0] tbl [NOTE_MAX+1];

    for (genvar i = 0; i <= NOTE_MAX; i++) begin : g_tbl
        localparam longint HV = note_half(i, CLK_HZ, CNT_BW);
        assign tbl[i] = HV[CNT_BW-1:0];
    end

    assign h_o = note_i[7] ? CNT_BW'(H_MUTE) : tbl[note_i[6:0]];

endmodule

// File: rtl/poly_osc.sv
// poly_osc: polyphonic square/pulse oscillator bank.
//   clk_i, rst_i   clock, synchronous active-high reset
//   enable_i [V]   per-voice gate; a rising gate restarts the voice at phase 0
//   note_i  [8V]   per-voice MIDI note, voice v at [8v+7:8v]
//   duty_i  [8V]   per-voice duty (only when POLY_OSC_PWM_EN is defined)
//   wave_o  [V]    per-voice registered wave
//   mix_o          registered count of high bits of wave_o (one cycle behind)
// Build option: define POLY_OSC_PWM_EN for pulse-width modulation; without it
// every voice is a 50% square wave and no multiplier exists.
module poly_osc
    import poly_osc_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int CNT_BW = 22,
    parameter int CLK_HZ = 50_000_000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [VOICES-1:0]          enable_i,
    input  logic [8*VOICES-1:0]        note_i,
`ifdef POLY_OSC_PWM_EN
    input  logic [8*VOICES-1:0]        duty_i,
`endif
    output logic [VOICES-1:0]          wave_o,
    output logic [mix_w(VOICES)-1:0]   mix_o
);

    localparam int CW = CNT_BW + 1;
    localparam int MW = mix_w(VOICES);

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        logic [CNT_BW-1:0] h;
        logic [CW-1:0]     p_new, t_new;
        logic [CW-1:0]     cnt_q, cnt_d, p_q, p_d, t_q, t_d;
        logic              wave_q, wave_d, en_prev_q, en_prev_d;
        logic              wrap;

        poly_note_lut #(.CLK_HZ(CLK_HZ), .CNT_BW(CNT_BW)) u_lut (
            .note_i (note_i[8*v +: 8]),
            .h_o    (h)
        );

        assign p_new = {h, 1'b0};

`ifdef POLY_OSC_PWM_EN
        logic [CW+7:0] prod;
        assign prod  = (CW+8)'(p_new) * (CW+8)'(duty_i[8*v +: 8]);
        // Low time is P - (P*duty)>>8, so duty 128 reproduces the square wave.
        assign t_new = p_new - prod[CW+7:8];
`else
        assign t_new = {1'b0, h};
`endif

        assign wrap = (cnt_q == p_q - CW'(1));

        always_comb begin
            cnt_d     = cnt_q;
            p_d       = p_q;
            t_d       = t_q;
            wave_d    = wave_q;
            en_prev_d = enable_i[v];
            if (!enable_i[v]) begin
                cnt_d  = '0;
                wave_d = 1'b0;
            end else if (!en_prev_q || (p_q == '0) || wrap) begin
                // Gate rise, muted voice or period end: take the current note
                // and restart the period. Wrap wins over a pending rise.
                p_d    = p_new;
                t_d    = t_new;
                cnt_d  = '0;
                wave_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == t_q - CW'(1)) wave_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_q     <= '0;
                p_q       <= '0;
                t_q       <= '0;
                wave_q    <= 1'b0;
                en_prev_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                p_q       <= p_d;
                t_q       <= t_d;
                wave_q    <= wave_d;
                en_prev_q <= en_prev_d;
            end
        end

        assign wave_o[v] = wave_q;
    end

    logic [MW-1:0] mix_q, mix_d;

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < VOICES; i++) mix_d = mix_d + MW'(wave_o[i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) mix_q <= '0;
        else       mix_q <= mix_d;
    end

    assign mix_o = mix_q;

endmodule

// File: tb/tb_poly_osc.sv
// tb_poly_osc: directed bench for poly_osc at CLK_HZ = 1 MHz, four voices.
// H(69) = 1136, H(81) = 568, H(60) = 1911.
module tb_poly_osc;

    localparam int VOICES = 4;
    localparam int CNT_BW = 22;
    localparam int CLK_HZ = 1_000_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  en  = '0;
    logic [7:0]  note = 8'd69;
    logic [7:0]  duty = 8'd128;
    logic [31:0] note_bus;
    logic [3:0]  wave;
    logic [2:0]  mix;

    int total = 0;
    int bad   = 0;

    assign note_bus = {4{note}};

`ifdef POLY_OSC_PWM_EN
    logic [31:0] duty_bus;
    assign duty_bus = {4{duty}};
`endif

    poly_osc #(.VOICES(VOICES), .CNT_BW(CNT_BW), .CLK_HZ(CLK_HZ)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en),
        .note_i   (note_bus),
`ifdef POLY_OSC_PWM_EN
        .duty_i   (duty_bus),
`endif
        .wave_o   (wave),
        .mix_o    (mix)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic [7:0] note;
        int         cyc;
        logic [3:0] wave;
        logic [2:0] mix;
    } vec_t;

    vec_t tv [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = '0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int seen;
        logic [3:0] sw [5];
        logic [2:0] sm [5];

        // Voice 0, note 69; row k = edge of the enable rise.
        tv[0]  = '{4'b0000, 8'd69, 1,    4'b0000, 3'd0};
        tv[1]  = '{4'b0001, 8'd69, 1,    4'b0000, 3'd0};  // k
        tv[2]  = '{4'b0001, 8'd69, 1135, 4'b0000, 3'd0};  // k+1135
        tv[3]  = '{4'b0001, 8'd69, 1,    4'b0001, 3'd0};  // k+1136 rise
        tv[4]  = '{4'b0001, 8'd69, 1,    4'b0001, 3'd1};  // mix follows
        tv[5]  = '{4'b0001, 8'd69, 1134, 4'b0001, 3'd1};  // k+2271
        tv[6]  = '{4'b0001, 8'd69, 1,    4'b0000, 3'd1};  // k+2272 fall
        tv[7]  = '{4'b0001, 8'd69, 1,    4'b0000, 3'd0};
        tv[8]  = '{4'b0001, 8'd69, 5678, 4'b0000, 3'd0};  // k+7951
        tv[9]  = '{4'b0001, 8'd69, 1,    4'b0001, 3'd0};  // k+7952 4th rise
        tv[10] = '{4'b0001, 8'd69, 1135, 4'b0001, 3'd1};  // k+9087
        tv[11] = '{4'b0001, 8'd69, 1,    4'b0000, 3'd1};  // k+9088 end of 4 periods
        tv[12] = '{4'b0001, 8'd69, 1136, 4'b0001, 3'd0};  // k+10224 high phase
        tv[13] = '{4'b0001, 8'd81, 1135, 4'b0001, 3'd1};  // new note ignored mid-period
        tv[14] = '{4'b0001, 8'd81, 1,    4'b0000, 3'd1};  // k+11360 wrap latches 81
        tv[15] = '{4'b0001, 8'd81, 567,  4'b0000, 3'd0};
        tv[16] = '{4'b0001, 8'd81, 1,    4'b0001, 3'd0};  // rise after 568
        tv[17] = '{4'b0001, 8'd81, 567,  4'b0001, 3'd1};
        tv[18] = '{4'b0001, 8'd81, 1,    4'b0000, 3'd1};  // period 1136

        // Reset state
        tick(3);
        chk("reset_wave", 32'(wave), 32'd0);
        chk("reset_mix",  32'(mix),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            en   = tv[i].en;
            note = tv[i].note;
            tick(tv[i].cyc);
            chk($sformatf("vec%0d_wave", i), 32'(wave), 32'(tv[i].wave));
            chk($sformatf("vec%0d_mix", i),  32'(mix),  32'(tv[i].mix));
        end

        // Out-of-range notes stay silent; a valid note then starts H(60) later.
        en = '0; note = 8'd200; tick(1);
        en = 4'b0001;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (wave != 0 || mix != 0) seen++;
        end
        chk("mute_200", seen, 0);
        note = 8'd130;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (wave != 0 || mix != 0) seen++;
        end
        chk("mute_130", seen, 0);
        note = 8'd60;
        tick(1911);
        chk("n60_before_rise", 32'(wave), 32'd0);
        tick(1);
        chk("n60_rise", 32'(wave), 32'd1);

        // Reset mid high phase, restart as an enable rise, then gate drop and re-enable.
        do_reset();
        note = 8'd69; en = 4'b0001;
        tick(1200);
        chk("pre_rst_high", 32'(wave), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("rst_wave", 32'(wave), 32'd0);
        chk("rst_mix",  32'(mix),  32'd0);
        rst = 1'b0;
        tick(1136);
        chk("rst_restart_low", 32'(wave), 32'd0);
        tick(1);
        chk("rst_restart_rise", 32'(wave), 32'd1);
        tick(100);
        en = '0;
        tick(1);
        chk("gate_drop_wave", 32'(wave), 32'd0);
        tick(1);
        chk("gate_drop_mix", 32'(mix), 32'd0);
        en = 4'b0001;
        tick(1136);
        chk("reen_low", 32'(wave), 32'd0);
        tick(1);
        chk("reen_rise", 32'(wave), 32'd1);

        // Staggered enables: mix counts up and down one cycle behind wave.
        do_reset();
        note = 8'd69;
        en = 4'b0001; tick(1);
        en = 4'b0011; tick(1);
        en = 4'b0111; tick(1);
        en = 4'b1111; tick(1);
        tick(1133);
        sw = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        sm = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(1);
            chk($sformatf("stag_up%0d_wave", i), 32'(wave), 32'(sw[i]));
            chk($sformatf("stag_up%0d_mix", i),  32'(mix),  32'(sm[i]));
        end
        tick(1132);
        sw = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
        sm = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(1);
            chk($sformatf("stag_dn%0d_wave", i), 32'(wave), 32'(sw[i]));
            chk($sformatf("stag_dn%0d_mix", i),  32'(mix),  32'(sm[i]));
        end

`ifdef POLY_OSC_PWM_EN
        // Duty 64: T = 1704, high 568 of 2272.
        do_reset();
        note = 8'd69; duty = 8'd64; en = 4'b0001;
        tick(1);
        tick(1703);
        chk("d64_low", 32'(wave), 32'd0);
        tick(1);
        chk("d64_rise", 32'(wave), 32'd1);
        tick(567);
        chk("d64_high_end", 32'(wave), 32'd1);
        tick(1);
        chk("d64_fall", 32'(wave), 32'd0);
        // Duty 0: never high.
        do_reset();
        duty = 8'd0; en = 4'b0001;
        seen = 0;
        for (int i = 0; i < 4544; i++) begin
            tick(1);
            if (wave != 0) seen++;
        end
        chk("d0_silent", seen, 0);
        // Duty 255: low 9 cycles, high 2263.
        do_reset();
        duty = 8'd255; en = 4'b0001;
        tick(1);
        tick(8);
        chk("d255_low", 32'(wave), 32'd0);
        tick(1);
        chk("d255_rise", 32'(wave), 32'd1);
        tick(2262);
        chk("d255_high_end", 32'(wave), 32'd1);
        tick(1);
        chk("d255_fall", 32'(wave), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
